axi_regfile_s00_axi: RTL and testbench

AXI4-Lite slave register file exposing `NREGS` 32-bit read/write control registers to a processor or AXI master. It sits between the AXI interconnect and fabric logic:
- The written values drive the fabric directly on `slv_reg`.
- Reads return the fabric-supplied `slv_read` vector, usually a loopback of `slv_reg` or status inputs.
- A per-register write pulse tells the fabric when software wrote each register.

---
 rtl/axi_regfile_s00_axi_pkg.sv | 7 +
 rtl/axi_regfile_s00_axi.sv | 100 ++++++++++
 tb/tb_axi_regfile_s00_axi.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_regfile_s00_axi_pkg.sv
// Shared constants for the AXI4-Lite register file slave.
package axi_regfile_s00_axi_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int         BYTE_W    = 8;

endpackage

// File: rtl/axi_regfile_s00_axi.sv
// AXI4-Lite slave exposing NREGS 32-bit control registers to fabric logic.
// Writes land in slv_reg with a one-cycle per-bit write pulse; reads return
// the fabric-supplied slv_read vector. Every index decodes, so the slave
// always answers OKAY.
module axi_regfile_s00_axi
  import axi_regfile_s00_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  localparam int NREGS = 2 ** (C_S_AXI_ADDR_WIDTH - 2)
) (
  input  logic                                      S_AXI_ACLK,
  input  logic                                      S_AXI_ARESET,
  input  logic [NREGS-1:0][C_S_AXI_DATA_WIDTH-1:0]  slv_read,
  output logic [NREGS-1:0][C_S_AXI_DATA_WIDTH-1:0]  slv_reg,
  output logic [NREGS-1:0][C_S_AXI_DATA_WIDTH-1:0]  slv_wr_pulse,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_AWADDR,
  input  logic [2:0]                                S_AXI_AWPROT,
  input  logic                                      S_AXI_AWVALID,
  output logic                                      S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]           S_AXI_WSTRB,
  input  logic                                      S_AXI_WVALID,
  output logic                                      S_AXI_WREADY,
  output logic [1:0]                                S_AXI_BRESP,
  output logic                                      S_AXI_BVALID,
  input  logic                                      S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_ARADDR,
  input  logic [2:0]                                S_AXI_ARPROT,
  input  logic                                      S_AXI_ARVALID,
  output logic                                      S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_RDATA,
  output logic [1:0]                                S_AXI_RRESP,
  output logic                                      S_AXI_RVALID,
  input  logic                                      S_AXI_RREADY
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / BYTE_W;

  logic                          wr_accept;
  logic                          rd_accept;
  logic [C_S_AXI_ADDR_WIDTH-3:0] wr_idx;
  logic [C_S_AXI_ADDR_WIDTH-3:0] rd_idx;
  logic                          unused_ok;

  assign wr_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // Ready is combinational so a write can be accepted the cycle after the
  // previous response handshakes, giving one write per two cycles. Gating
  // with reset keeps the readies low while reset is held.
  assign wr_accept = S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_ARESET;
  assign rd_accept = S_AXI_ARVALID && !S_AXI_RVALID && !S_AXI_ARESET;

  assign S_AXI_AWREADY = wr_accept;
  assign S_AXI_WREADY  = wr_accept;
  assign S_AXI_ARREADY = rd_accept;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RRESP   = RESP_OKAY;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write channel: byte-strobed register update, one-cycle write pulse, B response.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      slv_reg      <= '0;
      slv_wr_pulse <= '0;
      S_AXI_BVALID <= 1'b0;
    end else begin
      slv_wr_pulse <= '0;
      if (wr_accept) begin
        S_AXI_BVALID <= 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (S_AXI_WSTRB[b]) begin
            slv_reg[wr_idx][b*BYTE_W +: BYTE_W]      <= S_AXI_WDATA[b*BYTE_W +: BYTE_W];
            slv_wr_pulse[wr_idx][b*BYTE_W +: BYTE_W] <= {BYTE_W{1'b1}};
          end
        end
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // Read channel: capture slv_read on acceptance and hold it until RREADY.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
    end else begin
      if (rd_accept) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= slv_read[rd_idx];
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_regfile_s00_axi.sv
// Bench for the AXI4-Lite register file: directed transactions push expected
// responses into queues, a monitor pops and compares on each handshake.
module tb_axi_regfile_s00_axi;

  logic              clk;
  logic              rst;
  logic [15:0][31:0] slv_read;
  logic [15:0][31:0] slv_reg;
  logic [15:0][31:0] slv_wr_pulse;
  logic [5:0]        awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [5:0]        araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  bq[$];
  logic [31:0] rq[$];

  axi_regfile_s00_axi #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .slv_read(slv_read), .slv_reg(slv_reg), .slv_wr_pulse(slv_wr_pulse),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  assign slv_read = slv_reg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare every B and R handshake against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (bvalid && bready) begin
        if (bq.size() == 0) check("unexpected_b", 1, 0);
        else check("bresp", 512'(bresp), 512'(bq.pop_front()));
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) check("unexpected_r", 1, 0);
        else begin
          check("rdata", 512'(rdata), 512'(rq.pop_front()));
          check("rresp", 512'(rresp), 512'(2'b00));
        end
      end
    end
  end

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [31:0] exp_reg, input logic [31:0] exp_pulse);
    int n;
    logic [15:0][31:0] exp_p;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    bq.push_back(2'b00);
    n = 0;
    do begin @(negedge clk); n++; end while (!(awready && wready) && n < 20);
    if (n >= 20) check("wr_accept_timeout", 0, 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    exp_p = '0;
    exp_p[a[5:2]] = exp_pulse;
    check("wr_reg", 512'(slv_reg[a[5:2]]), 512'(exp_reg));
    check("wr_pulse", 512'(slv_wr_pulse), 512'(exp_p));
    check("wr_bvalid", 512'(bvalid), 1);
    @(negedge clk);
    check("wr_pulse_clear", 512'(slv_wr_pulse), 0);
    check("wr_bvalid_clear", 512'(bvalid), 0);
  endtask

  task automatic do_read(input logic [5:0] a, input logic [31:0] exp);
    int n;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    rq.push_back(exp);
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    if (n >= 20) check("rd_accept_timeout", 0, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("rd_rvalid", 512'(rvalid), 1);
    @(negedge clk);
    check("rd_rvalid_clear", 512'(rvalid), 0);
  endtask

  initial begin
    logic [31:0] full_addr;
    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_slv_reg", 512'(slv_reg), 0);
    check("rst_pulse", 512'(slv_wr_pulse), 0);
    check("rst_readies", 512'({awready, wready, arready}), 0);
    check("rst_valids", 512'({bvalid, rvalid}), 0);
    check("rst_rdata", 512'(rdata), 0);
    check("rst_resps", 512'({bresp, rresp}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", 512'({awready, wready, arready, bvalid, rvalid, rdata}), 0);

    // Fill all sixteen registers, upper master address bits dropped by the port.
    for (int i = 0; i < 16; i++) begin
      full_addr = 32'h4000_0000 + 32'(4 * i);
      do_write(full_addr[5:0], 32'hAA00_0000 + 32'(i), 4'hF, 32'hAA00_0000 + 32'(i), 32'hFFFF_FFFF);
    end
    for (int i = 0; i < 16; i++) begin
      full_addr = 32'h4000_0000 + 32'(4 * i);
      do_read(full_addr[5:0], 32'hAA00_0000 + 32'(i));
    end
    do_read(6'h0B, 32'hAA00_0002);

    // Byte strobe.
    do_write(6'h0C, 32'h1122_3344, 4'hF, 32'h1122_3344, 32'hFFFF_FFFF);
    do_write(6'h0C, 32'hAABB_CCDD, 4'h5, 32'h11BB_33DD, 32'h00FF_00FF);
    do_read(6'h0C, 32'h11BB_33DD);

    // Channel skew: AW leads W by three cycles.
    @(posedge clk); #1;
    awaddr = 6'h14; awvalid = 1'b1; bready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("skew_no_accept", 512'({awready, wready}), 0);
      @(posedge clk); #1;
    end
    wdata = 32'hCAFE_0005; wstrb = 4'hF; wvalid = 1'b1;
    bq.push_back(2'b00);
    @(negedge clk);
    check("skew_accept", 512'({awready, wready}), 512'(2'b11));
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("skew_bvalid", 512'(bvalid), 1);
    check("skew_reg", 512'(slv_reg[5]), 512'(32'hCAFE_0005));
    @(negedge clk);

    // Write back-pressure: second write waits for the B handshake.
    @(posedge clk); #1;
    bready = 1'b0; awaddr = 6'h18; wdata = 32'h6666_6666; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    bq.push_back(2'b00);
    @(negedge clk);
    check("bp_w_accept1", 512'(awready), 1);
    @(posedge clk); #1;
    awaddr = 6'h1C; wdata = 32'h7777_7777;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_w_hold", 512'({bvalid, awready, wready}), 512'(3'b100));
      @(posedge clk); #1;
    end
    check("bp_w_reg6", 512'(slv_reg[6]), 512'(32'h6666_6666));
    bready = 1'b1;
    bq.push_back(2'b00);
    @(negedge clk);
    check("bp_w_handshake_cycle", 512'(awready), 0);
    @(negedge clk);
    check("bp_w_accept2", 512'({awready, wready}), 512'(2'b11));
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("bp_w_reg7", 512'(slv_reg[7]), 512'(32'h7777_7777));
    @(negedge clk);

    // Read back-pressure: RDATA held, second read waits for the R handshake.
    @(posedge clk); #1;
    rready = 1'b0; araddr = 6'h18; arvalid = 1'b1;
    rq.push_back(32'h6666_6666);
    @(negedge clk);
    check("bp_r_accept1", 512'(arready), 1);
    @(posedge clk); #1;
    araddr = 6'h1C;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_r_hold", 512'({rvalid, arready}), 512'(2'b10));
      check("bp_r_rdata_stable", 512'(rdata), 512'(32'h6666_6666));
      @(posedge clk); #1;
    end
    rready = 1'b1;
    rq.push_back(32'h7777_7777);
    @(negedge clk);
    check("bp_r_handshake_cycle", 512'(arready), 0);
    @(negedge clk);
    check("bp_r_accept2", 512'(arready), 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Simultaneous read and write of register 0.
    @(posedge clk); #1;
    awaddr = 6'h00; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 6'h00; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    bq.push_back(2'b00);
    rq.push_back(32'hAA00_0000);
    @(negedge clk);
    check("sim_accept", 512'({awready, arready}), 512'(2'b11));
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("sim_reg0", 512'(slv_reg[0]), 512'(32'h1234_5678));
    @(negedge clk);
    do_read(6'h00, 32'h1234_5678);

    // Reset while BVALID is pending drops the response.
    @(posedge clk); #1;
    bready = 1'b0; awaddr = 6'h04; wdata = 32'h0BAD_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    bq.push_back(2'b00);
    @(negedge clk);
    check("rst_mid_accept", 512'(awready), 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("rst_mid_bvalid", 512'(bvalid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_bvalid_cleared", 512'(bvalid), 0);
    check("rst_mid_regs_cleared", 512'(slv_reg), 0);
    void'(bq.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    bready = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_b", 512'(bvalid), 0);

    check("bq_empty", 512'(bq.size()), 0);
    check("rq_empty", 512'(rq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
